// File: rtl/divider_32.sv
// divider_32: sequential 32-bit restoring divider, signed/unsigned, fixed 33-cycle latency.
module divider_32 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  div_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_n;
    logic        sign_a, sign_b;
    logic [31:0] a_orig, b_mag, work, work_n;
    logic [32:0] part, part_n;
    logic [33:0] part_sh, diff;
    logic [5:0]  cnt;
    logic        last;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last      = (cnt == 6'd31);
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = (state == IDLE && in_valid) ? CALC :
                  (state == CALC && last)     ? DONE :
                  (state == DONE && out_ready) ? IDLE : state;
        part_sh = {part, work[31]};
        diff    = part_sh - {2'b0, b_mag};
        part_n  = diff[33] ? part_sh[32:0] : diff[32:0];
        work_n  = {work[30:0], ~diff[33]};
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            part        <= '0;
            work        <= '0;
            a_orig      <= '0;
            b_mag       <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                sign_a <= div_signed & dividend[31];
                sign_b <= div_signed & divisor[31];
                a_orig <= dividend;
                work   <= (div_signed & dividend[31]) ? -dividend : dividend;
                b_mag  <= (div_signed & divisor[31]) ? -divisor : divisor;
                cnt    <= '0;
                part   <= '0;
            end
            if (state == CALC) begin
                part <= part_n;
                work <= work_n;
                cnt  <= cnt + 6'd1;
            end
            // zero divisor bypasses sign correction and reports the raw dividend
            if (state == CALC && last) begin
                quotient    <= (b_mag == '0) ? '1 : ((sign_a ^ sign_b) ? -work_n : work_n);
                remainder   <= (b_mag == '0) ? a_orig : (sign_a ? -part_n[31:0] : part_n[31:0]);
                div_by_zero <= (b_mag == '0);
            end
        end
    end
endmodule

// File: doc/divider_32.md
# divider_32

Sequential 32-bit integer divider with valid/ready handshakes on both sides, computing quotient and remainder in signed or unsigned mode. It sits beside the combinational ALU in the custom CPU execute stage and handles DIV/DIVU/REM/REMU. It accepts an operand pair from the execute stage, iterates one restoring-division step per cycle, and returns the result to the writeback side. Latency is fixed, including for divide-by-zero.

## Interface
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- clk  input  1  rising-edge clock; the only clock.
- resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  divider can accept operands; high only in IDLE.
- dividend  input  32  numerator; captured on the accept edge.
- divisor  input  32  denominator; captured on the accept edge.
- div_signed  input  1  1 selects two's-complement operands; 0 selects unsigned. Captured on the accept edge.
- out_valid  output  1  quotient/remainder valid.
- out_ready  input  1  consumer accepts the result.
- quotient  output  32  quotient.
- remainder  output  32  remainder.
- div_by_zero  output  1  the captured divisor was 0; qualified by out_valid.

## Operation
- FSM states and transitions:
  - IDLE -> CALC on in_valid && in_ready.
  - CALC -> DONE after the 32nd iteration.
  - DONE -> IDLE on out_valid && out_ready.
- Capture in IDLE:
  - Record the operand signs: sign_a = div_signed & dividend[31]; sign_b = div_signed & divisor[31].
  - Store magnitudes |dividend| and |divisor| as 32-bit unsigned values. |0x80000000| = 0x80000000.
  - Iteration counter <= 0. Partial remainder (33 bits) <= 0.
- Each CALC cycle performs one restoring step:
  - Shift {partial remainder, working dividend} left by 1.
  - Trial-subtract the divisor magnitude; if the result is non-negative, keep it and set quotient bit = 1, else restore and set quotient bit = 0.
  - counter++.
- Sign correction on the transition into DONE:
  - Quotient is negated if sign_a ^ sign_b.
  - Remainder is negated if sign_a; the remainder sign always follows the dividend.
- Divide by zero (divisor == 0 in either mode):
  - quotient = 0xFFFFFFFF, remainder = original dividend, div_by_zero = 1.
  - Still takes full latency; sign correction is bypassed.
- Signed overflow (0x80000000 / 0xFFFFFFFF, signed): quotient = 0x80000000, remainder = 0, div_by_zero = 0. This falls out of the magnitude algorithm; no special case is required.
- Outputs are registered:
  - quotient, remainder and div_by_zero hold stable while out_valid = 1 and out_ready = 0.
  - They retain their last values in IDLE.
- in_valid while busy is ignored; the producer must hold its request until in_ready.
- Reset (resetn = 0 at an edge), including mid-CALC or in DONE:
  - state -> IDLE; out_valid = 0; quotient = remainder = 0; div_by_zero = 0; counter = 0.
  - Any in-flight operation is discarded.

## Timing
- in_ready = (state == IDLE), combinational from state. After the first reset edge, in_ready = 1.
- Accept on edge T. CALC iterations occur on edges T+1 … T+32.
- State becomes DONE at edge T+32; out_valid is high from the cycle after edge T+32.
- Minimum occupancy is 33 cycles from accept to out_valid.
- Result handshake completes at the first edge with out_valid && out_ready. That edge moves state to IDLE, so in_ready is high in the following cycle.
- No same-cycle result-out/operand-in overlap; the minimum issue interval is 34 cycles when out_ready is held high.
- out_valid never drops without a handshake, except on reset.

## Test plan
- Unsigned 100 / 7, out_ready = 1: out_valid is first high exactly 33 cycles after the accept edge; quotient = 14, remainder = 2, div_by_zero = 0.
- Signed -7 / 2 (0xFFFFFFF9 / 0x00000002): quotient = 0xFFFFFFFD (-3), remainder = 0xFFFFFFFF (-1). Also check 7 / -2: quotient = -3, remainder = +1.
- Divide by zero, signed and unsigned, dividend 0x12345678, divisor 0: quotient = 0xFFFFFFFF, remainder = 0x12345678, div_by_zero = 1, latency 33.
- Signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. Unsigned 0xFFFFFFFF / 1: quotient = 0xFFFFFFFF, remainder = 0.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid rises.
  - Outputs stay stable and in_ready stays 0; in_valid pulses issued in that window are not accepted.
  - Release out_ready: in_ready rises the next cycle.
- Reset in the middle of CALC (cycle 15): all outputs go to 0 and in_ready = 1 after the reset edge. A new 9 / 3 then returns quotient 3, remainder 0 with full 33-cycle latency.
